hazard_stall_unit: RTL

- Pipeline control block beside the forwarding unit. It handles the hazards that forwarding cannot resolve: load-use dependencies, data-memory wait states and taken-branch flushes.
- It drives the stall, flush and bubble controls for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- It holds a small FSM for bounded data-memory waits with timeout, plus saturating performance counters for stalls and flushes.

---
 rtl/hazard_stall_unit_pkg.sv | 16 +
 rtl/hazard_stall_unit_sat_counter.sv | 29 ++
 rtl/hazard_stall_unit.sv | 130 +++++++++++++
 3 files changed

// File: rtl/hazard_stall_unit_pkg.sv
// rtl/hazard_stall_unit_pkg.sv - shared pipeline types and constants for hazard control
package hazard_stall_unit_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } hsu_state_t;

    // Instruction word the bubble/flush consumers load in place of a real op (addi x0,x0,0)
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [4:0] REG_X0 = 5'd0;

    localparam int WAIT_CNT_W = 8;

endpackage

// File: rtl/hazard_stall_unit_sat_counter.sv
// rtl/hazard_stall_unit_sat_counter.sv - saturating event counter with synchronous clear
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] LP_ONE = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] r_count;

    // Clear wins over increment; increment stops at all-ones instead of wrapping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (inc && (r_count != {W{1'b1}})) begin
            r_count <= r_count + LP_ONE;
        end
    end

    assign count = r_count;

endmodule

// File: rtl/hazard_stall_unit.sv
// rtl/hazard_stall_unit.sv - load-use, data-memory wait and branch-flush pipeline control
module hazard_stall_unit
    import hazard_stall_unit_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int COUNT_W     = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [4:0]         id_rs1,
    input  logic [4:0]         id_rs2,
    input  logic               id_use_rs1,
    input  logic               id_use_rs2,
    input  logic [4:0]         ex_rd,
    input  logic               ex_mem_read,
    input  logic               ex_branch_taken,
    input  logic               mem_access,
    input  logic               dmem_ready,
    input  logic               clr_counts,
    output logic               pc_stall,
    output logic               if_id_stall,
    output logic               if_id_flush,
    output logic               id_ex_stall,
    output logic               id_ex_bubble,
    output logic               ex_mem_stall,
    output logic               mem_wb_bubble,
    output logic               mem_fault,
    output logic [COUNT_W-1:0] stall_count,
    output logic [COUNT_W-1:0] flush_count
);

    localparam logic [WAIT_CNT_W-1:0] LP_TIMEOUT = WAIT_CNT_W'(MEM_TIMEOUT);
    localparam logic [WAIT_CNT_W-1:0] LP_ONE     = {{(WAIT_CNT_W-1){1'b0}}, 1'b1};

    hsu_state_t            r_state;
    hsu_state_t            w_state_nxt;
    logic [WAIT_CNT_W-1:0] r_wait_cnt;
    logic [WAIT_CNT_W-1:0] w_wait_cnt_nxt;

    logic w_memwait;
    logic w_loaduse;
    logic w_timeout;

    logic w_pc_stall;
    logic w_if_id_stall;
    logic w_if_id_flush;
    logic w_id_ex_stall;
    logic w_id_ex_bubble;
    logic w_ex_mem_stall;
    logic w_mem_wb_bubble;
    logic w_mem_fault;

    assign w_memwait = mem_access & ~dmem_ready;
    assign w_loaduse = ex_mem_read & (ex_rd != REG_X0) &
                       ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));
    assign w_timeout = (r_state == MEM_WAIT) & (r_wait_cnt == LP_TIMEOUT) & ~dmem_ready;

    // Wait FSM state and consecutive-wait counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= RUN;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
        end
    end

    // Prioritised control decode: timeout, memory freeze, branch flush, load-use bubble
    always_comb begin
        w_pc_stall      = 1'b0;
        w_if_id_stall   = 1'b0;
        w_if_id_flush   = 1'b0;
        w_id_ex_stall   = 1'b0;
        w_id_ex_bubble  = 1'b0;
        w_ex_mem_stall  = 1'b0;
        w_mem_wb_bubble = 1'b0;
        w_mem_fault     = 1'b0;
        w_state_nxt     = RUN;
        w_wait_cnt_nxt  = '0;

        if (w_timeout) begin
            // Let the stuck MEM op retire; the trap is raised downstream
            w_mem_fault = 1'b1;
        end else if (w_memwait) begin
            w_pc_stall      = 1'b1;
            w_if_id_stall   = 1'b1;
            w_id_ex_stall   = 1'b1;
            w_ex_mem_stall  = 1'b1;
            w_mem_wb_bubble = 1'b1;
            w_state_nxt     = MEM_WAIT;
            w_wait_cnt_nxt  = r_wait_cnt + LP_ONE;
        end else if (ex_branch_taken) begin
            // ID instruction is on the wrong path, so any load-use against it is moot
            w_if_id_flush  = 1'b1;
            w_id_ex_bubble = 1'b1;
        end else if (w_loaduse) begin
            w_pc_stall     = 1'b1;
            w_if_id_stall  = 1'b1;
            w_id_ex_bubble = 1'b1;
        end
    end

    // Force controls quiet while reset is held, even if inputs look like a hazard
    assign pc_stall      = rst_n & w_pc_stall;
    assign if_id_stall   = rst_n & w_if_id_stall;
    assign if_id_flush   = rst_n & w_if_id_flush;
    assign id_ex_stall   = rst_n & w_id_ex_stall;
    assign id_ex_bubble  = rst_n & w_id_ex_bubble;
    assign ex_mem_stall  = rst_n & w_ex_mem_stall;
    assign mem_wb_bubble = rst_n & w_mem_wb_bubble;
    assign mem_fault     = rst_n & w_mem_fault;

    sat_counter #(.W(COUNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_pc_stall),
        .clr   (clr_counts),
        .count (stall_count)
    );

    sat_counter #(.W(COUNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_if_id_flush),
        .clr   (clr_counts),
        .count (flush_count)
    );

endmodule
